// File: rtl/inst_memory_write_arbiter.sv
// rtl/inst_memory_write_arbiter.sv - two-requester write-port arbiter for the instruction memory
module inst_memory_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_window,
  input  logic                  req_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  req_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  ack_a,
  output logic                  ack_b,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [4:0]            write_count
);

  // IDLE samples requests, CAPTURE latches the winner's word, WRITE commits,
  // DONE holds the one-cycle write/ack pulse so the requester can retire its
  // request before IDLE samples again.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0] state;
  logic       ptr_b;     // 1: B has priority when both request
  logic       win_b;     // registered winner of the current transaction
  logic       window_d;
  logic       commit;
  logic       window_rise;
  logic       pick_b;

  assign pick_b      = req_b && (!req_a || ptr_b);
  assign commit      = (state == ST_WRITE) && write_window;
  assign window_rise = write_window && !window_d;

  // Arbitration FSM, memory write port and acknowledges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ptr_b    <= 1'b0;
      win_b    <= 1'b0;
      mem_we   <= 1'b0;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      mem_we <= 1'b0;
      ack_a  <= 1'b0;
      ack_b  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (write_window && (req_a || req_b)) begin
            win_b <= pick_b;
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (write_window) begin
            mem_addr <= win_b ? addr_b : addr_a;
            mem_data <= win_b ? data_b : data_a;
            state    <= ST_WRITE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (write_window) begin
            mem_we <= 1'b1;
            ack_a  <= !win_b;
            ack_b  <= win_b;
            ptr_b  <= !win_b;
            state  <= ST_DONE;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-window commit counter: cleared when the window opens, saturates at 31.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      window_d    <= 1'b0;
      write_count <= 5'd0;
    end else begin
      window_d <= write_window;
      if (window_rise) begin
        write_count <= commit ? 5'd1 : 5'd0;
      end else if (commit && (write_count != 5'd31)) begin
        write_count <= write_count + 5'd1;
      end
    end
  end

endmodule
